regfile_mp: RTL and testbench

Parametrised multi-port register file for the multi-cycle CPU datapath. It is the successor of the fixed 32x32, two-read/one-write register file, generalised in data width, depth and read-port count. It adds byte-enabled writes, an optional hardwired-zero register, optional same-cycle write bypass, and a per-register busy scoreboard so the control unit can stall on pending results. It sits between the instruction decode stage (read addresses) and the write-back mux (write data).

---
 rtl/regfile_mp.sv | 139 +++++++++++++
 tb/tb_regfile_mp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// ----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file with byte-enabled writes, optional
//   hardwired-zero register 0, optional same-cycle write bypass to the read
//   ports, and a per-register busy scoreboard with a registered busy count.
//
// Parameters
//   DATA_W    register width in bits (multiple of 8)
//   ADDR_W    address width, depth = 2**ADDR_W
//   N_RD      number of read ports (1..4)
//   ZERO_REG  1 = register 0 reads 0 and ignores writes/reservations
//   BYPASS    1 = same-cycle write data forwarded to matching read ports
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   asynchronous active-low reset
//   ReadReg      in   read addresses, port i at [i*ADDR_W +: ADDR_W]
//   ReadData     out  read data, port i at [i*DATA_W +: DATA_W]
//   ReadBusy     out  per-port busy flag of the addressed register
//   RegWre       in   write enable
//   WriteReg     in   write address
//   WriteData    in   write data
//   WriteByteEn  in   per-byte write enable
//   RegReserve   in   mark ReserveReg busy
//   ReserveReg   in   register to reserve
//   BusyCount    out  number of busy registers (registered)
// ----------------------------------------------------------------------------
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int N_RD     = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [N_RD*ADDR_W-1:0]   ReadReg,
   output logic [N_RD*DATA_W-1:0]   ReadData,
   output logic [N_RD-1:0]          ReadBusy,
   input  logic                     RegWre,
   input  logic [ADDR_W-1:0]        WriteReg,
   input  logic [DATA_W-1:0]        WriteData,
   input  logic [DATA_W/8-1:0]      WriteByteEn,
   input  logic                     RegReserve,
   input  logic [ADDR_W-1:0]        ReserveReg,
   output logic [ADDR_W:0]          BusyCount
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int NB    = DATA_W / 8;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [ADDR_W:0]   r_busy_cnt;

   logic [DEPTH-1:0]  w_busy_nxt;
   logic              w_wr_ok;
   logic              w_rsv_ok;

   // True when the address names the hardwired-zero register.
   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Replace the enabled bytes of old_v with those of new_v.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_v,
      input logic [DATA_W-1:0] new_v,
      input logic [NB-1:0]     be
   );
      logic [DATA_W-1:0] v;
      v = old_v;
      for (int k = 0; k < NB; k++) begin
         if (be[k]) v[8*k +: 8] = new_v[8*k +: 8];
      end
      return v;
   endfunction

   function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] c;
      c = '0;
      for (int j = 0; j < DEPTH; j++) begin
         c = c + {{ADDR_W{1'b0}}, v[j]};
      end
      return c;
   endfunction

   assign w_wr_ok  = RegWre     && !is_zero_reg(WriteReg);
   assign w_rsv_ok = RegReserve && !is_zero_reg(ReserveReg);

   // Reservation is applied after the write clear so a new producer
   // reserving the register being written leaves it busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_ok)  w_busy_nxt[WriteReg]   = 1'b0;
      if (w_rsv_ok) w_busy_nxt[ReserveReg] = 1'b1;
   end

   // Count is taken from the next-state vector so it tracks the busy bits
   // without an extra cycle of lag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= popcount(w_busy_nxt);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
      end else if (w_wr_ok) begin
         r_mem[WriteReg] <= merge_bytes(r_mem[WriteReg], WriteData, WriteByteEn);
      end
   end

   assign BusyCount = r_busy_cnt;

   // Register 0 never gets written or reserved when ZERO_REG=1, and is
   // cleared by reset, so plain storage lookups already return 0 for it.
   for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_hit;

      assign w_addr = ReadReg[gi*ADDR_W +: ADDR_W];
      assign w_hit  = (BYPASS != 0) && RegWre && (WriteReg == w_addr) &&
                      !is_zero_reg(w_addr);

      assign ReadData[gi*DATA_W +: DATA_W] =
         !RST  ? '0 :
         w_hit ? merge_bytes(r_mem[w_addr], WriteData, WriteByteEn) :
                 r_mem[w_addr];

      assign ReadBusy[gi] = RST && !w_hit && r_busy[w_addr];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp
//   Bench for regfile_mp: one instance with bypass, one without, driven by
//   the same stimulus and compared against a behavioural array model.
// ----------------------------------------------------------------------------
module tb_regfile_mp;

   logic        CLK;
   logic        RST;
   logic [9:0]  ReadReg;
   logic        RegWre;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [3:0]  WriteByteEn;
   logic        RegReserve;
   logic [4:0]  ReserveReg;

   logic [63:0] rd_b,  rd_nb;
   logic [1:0]  bsy_b, bsy_nb;
   logic [5:0]  cnt_b, cnt_nb;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   logic [31:0] m_mem  [32];
   bit          m_busy [32];

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
      .CLK(CLK), .RST(RST), .ReadReg(ReadReg), .ReadData(rd_b), .ReadBusy(bsy_b),
      .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
      .WriteByteEn(WriteByteEn), .RegReserve(RegReserve), .ReserveReg(ReserveReg),
      .BusyCount(cnt_b));

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
      .CLK(CLK), .RST(RST), .ReadReg(ReadReg), .ReadData(rd_nb), .ReadBusy(bsy_nb),
      .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
      .WriteByteEn(WriteByteEn), .RegReserve(RegReserve), .ReserveReg(ReserveReg),
      .BusyCount(cnt_nb));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_data(input int a, input bit byp);
      logic [31:0] v;
      if (a == 0) return 32'h0;
      v = m_mem[a];
      if (byp && RegWre && (int'(WriteReg) == a))
         for (int k = 0; k < 4; k++)
            if (WriteByteEn[k]) v[8*k +: 8] = WriteData[8*k +: 8];
      return v;
   endfunction

   function automatic logic exp_busy(input int a, input bit byp);
      if (a == 0) return 1'b0;
      if (byp && RegWre && (int'(WriteReg) == a)) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic int exp_count();
      int c = 0;
      for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
      return c;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_mem[r]  = 32'h0;
         m_busy[r] = 1'b0;
      end
   endtask

   // Effect of one rising edge with reset released.
   task automatic model_clock();
      if (RegWre && WriteReg != 5'd0) begin
         for (int k = 0; k < 4; k++)
            if (WriteByteEn[k]) m_mem[WriteReg][8*k +: 8] = WriteData[8*k +: 8];
         m_busy[WriteReg] = 1'b0;
      end
      if (RegReserve && ReserveReg != 5'd0) m_busy[ReserveReg] = 1'b1;
   endtask

   task automatic check_all();
      int a;
      for (int p = 0; p < 2; p++) begin
         a = int'(ReadReg[p*5 +: 5]);
         chk($sformatf("rd%0d_byp a=%0d", p, a),  rd_b[p*32 +: 32],  exp_data(a, 1'b1));
         chk($sformatf("rd%0d_nbyp a=%0d", p, a), rd_nb[p*32 +: 32], exp_data(a, 1'b0));
         chk($sformatf("bsy%0d_byp a=%0d", p, a), bsy_b[p],  exp_busy(a, 1'b1));
         chk($sformatf("bsy%0d_nbyp a=%0d", p, a), bsy_nb[p], exp_busy(a, 1'b0));
      end
      chk("cnt_byp",  cnt_b,  exp_count());
      chk("cnt_nbyp", cnt_nb, exp_count());
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic rs, input logic [4:0] ra,
                        input logic [4:0] r0, input logic [4:0] r1);
      RegWre = we; WriteReg = wa; WriteData = wd; WriteByteEn = be;
      RegReserve = rs; ReserveReg = ra; ReadReg = {r1, r0};
   endtask

   // Inputs are already driven just after a falling edge; check, clock, return
   // at the next falling edge.
   task automatic cycle();
      #1;
      check_all();
      @(posedge CLK);
      model_clock();
      @(negedge CLK);
   endtask

   initial begin
      model_reset();
      RST = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);

      // Reset held; a write/reserve request is ignored
      #20;
      drive(1'b1, 5'd4, 32'hFFFF_FFFF, 4'hF, 1'b1, 5'd4, 5'd4, 5'd4);
      #2;
      chk("rst_rd_byp",  rd_b,  64'h0);
      chk("rst_bsy_byp", bsy_b, 64'h0);
      chk("rst_cnt",     cnt_b, 64'h0);
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      repeat (3) @(negedge CLK);   // t = 50 ns
      RST = 1'b1;

      // All registers read 0 / not busy after reset
      for (int r = 0; r < 32; r++) begin
         drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'(r), 5'(31 - r));
         cycle();
      end

      // Write / readback with byte enables
      drive(1'b1, 5'd2, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd2, 5'd0);
      cycle();
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd2, 5'd0);
      #1 chk("wr_full", rd_nb[31:0], 32'hDEADBEEF);
      cycle();
      drive(1'b1, 5'd2, 32'h00001100, 4'b0010, 1'b0, 5'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd2, 5'd2);
      #1 chk("wr_byte1", rd_nb[31:0], 32'hDEAD11EF);
      cycle();

      // Zero register ignores write and reservation
      drive(1'b1, 5'd0, 32'h12345678, 4'hF, 1'b1, 5'd0, 5'd0, 5'd0);
      #1 chk("zero_rd_same", rd_b[31:0], 32'h0);
      cycle();
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      chk("zero_rd",   rd_nb[31:0], 32'h0);
      chk("zero_bsy",  bsy_nb[0],   1'b0);
      chk("zero_cnt",  cnt_nb,      6'd0);
      cycle();

      // Bypass versus no bypass
      drive(1'b1, 5'd5, 32'hAAAAAAAA, 4'hF, 1'b0, 5'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd5, 32'h55555555, 4'b0011, 1'b0, 5'd0, 5'd0, 5'd5);
      #1;
      chk("byp_same",  rd_b[63:32],  32'hAAAA5555);
      chk("nbyp_same", rd_nb[63:32], 32'hAAAAAAAA);
      cycle();
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd5);
      #1 chk("nbyp_next", rd_nb[63:32], 32'hAAAA5555);
      cycle();

      // Scoreboard
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd7);
      cycle();
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7, 5'd3, 5'd7);
      #1;
      chk("sb_cnt1",  cnt_b, 6'd1);
      chk("sb_bsy3",  bsy_b[0], 1'b1);
      cycle();
      drive(1'b1, 5'd3, 32'h33333333, 4'hF, 1'b0, 5'd0, 5'd3, 5'd7);
      #1 chk("sb_cnt2", cnt_b, 6'd2);
      cycle();
      drive(1'b1, 5'd7, 32'hCAFEF00D, 4'hF, 1'b1, 5'd7, 5'd3, 5'd7);
      #1 chk("sb_cnt_after_wr", cnt_b, 6'd1);
      cycle();
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd7, 5'd3);
      #1;
      chk("sb_rsvwr_bsy",  bsy_nb[0],    1'b1);
      chk("sb_rsvwr_data", rd_nb[31:0],  32'hCAFEF00D);
      chk("sb_rsvwr_cnt",  cnt_nb,       6'd1);
      cycle();
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 5'd0, 5'd0);
      cycle();

      // Mid-operation reset pulse; the write pending at release is applied
      drive(1'b1, 5'd4, 32'h11223344, 4'hF, 1'b0, 5'd0, 5'd5, 5'd4);
      #1 RST = 1'b0;
      #1;
      chk("mrst_rd_byp",  rd_b,   64'h0);
      chk("mrst_rd_nbyp", rd_nb,  64'h0);
      chk("mrst_bsy",     bsy_b,  2'b00);
      chk("mrst_cnt",     cnt_b,  6'd0);
      chk("mrst_cnt_nb",  cnt_nb, 6'd0);
      model_reset();
      #1 RST = 1'b1;
      #1;
      check_all();
      @(posedge CLK);
      model_clock();
      @(negedge CLK);
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd4);
      #1;
      chk("mrst_wr_applied", rd_nb[63:32], 32'h11223344);
      chk("mrst_old_gone",   rd_nb[31:0],  32'h0);
      cycle();

      // Randomized traffic; small address range raises collision rate
      for (int n = 0; n < 600; n++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)), $urandom(),
               4'($urandom()), 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 11)),
               5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
